// File: rtl/mem_stage_pipe.sv
// Memory pipeline stage: accepts one load/store/pass-through op at a time,
// accesses a byte-lane data memory after a configurable latency and holds the
// formatted result until the downstream side takes it.

package mem_stage_pipe_pkg;
    typedef struct packed {
        logic       mem_read;
        logic       mem_write;
        logic [1:0] mem_size;   // 00 byte, 01 half, 1x word
        logic       mem_sign;
    } control_type;
endpackage

module mem_stage_pipe
    import mem_stage_pipe_pkg::*;
#(
    parameter int ADDR_BITS   = 10,
    parameter int LATENCY     = 1,
    parameter int ALIGN_CHECK = 1
) (
    input  logic        clk,
    input  logic        reset_n,        // active-high synchronous reset
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] alu_data_in,
    input  logic [31:0] memory_data_in,
    input  control_type control_in,
    input  logic [31:0] pc_in,
    output logic        out_valid,
    input  logic        out_ready,
    output control_type control_out,
    output logic [31:0] alu_data_out,
    output logic [31:0] pc_out,
    output logic [31:0] memory_data_out,
    output logic        misaligned_out,
    output logic        busy
);

    localparam int WIDX  = ADDR_BITS - 2;
    localparam int WORDS = 2 ** WIDX;

    typedef enum logic [1:0] {IDLE, WAIT, HOLD} state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        out_valid_q, out_valid_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    control_type ctrl_q, ctrl_d;
    logic [31:0] pc_q, pc_d;
    logic        mis_q, mis_d;
    logic        load_q, load_d;

    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
        case (size)
            2'b00:   misaligned = 1'b0;
            2'b01:   misaligned = off[0];
            default: misaligned = (off != 2'b00);
        endcase
    endfunction

    // Handshake and classification of the offered instruction.
    logic in_is_mem, in_mis, in_real, in_load, accept;
    assign in_ready  = !reset_n && (state_q == IDLE) && (!out_valid_q || out_ready);
    assign accept    = in_valid && in_ready;
    assign in_is_mem = control_in.mem_read || control_in.mem_write;
    assign in_mis    = in_is_mem && misaligned(control_in.mem_size, alu_data_in[1:0]);
    // A "real" op touches memory; trapped misaligned ops are passed through.
    assign in_real   = in_is_mem && !((ALIGN_CHECK != 0) && in_mis);
    assign in_load   = control_in.mem_read && !control_in.mem_write;

    // Memory access happens on the completion edge: the acceptance edge itself
    // when LATENCY is 1, otherwise the last WAIT cycle using the latched op.
    logic            wait_done, fast_mem, complete;
    logic            op_write;
    logic [1:0]      op_size, op_off;
    logic [WIDX-1:0] mem_idx;
    logic [31:0]     op_wdata;
    logic [2:0]      op_nbytes;

    assign wait_done = (state_q == WAIT) && (cnt_q == 4'd0);
    assign fast_mem  = accept && in_real && (LATENCY == 1);
    assign complete  = fast_mem || (wait_done && !reset_n);
    assign op_write  = wait_done ? ctrl_q.mem_write : control_in.mem_write;
    assign op_size   = wait_done ? ctrl_q.mem_size  : control_in.mem_size;
    assign op_off    = wait_done ? addr_q[1:0]      : alu_data_in[1:0];
    assign mem_idx   = wait_done ? addr_q[ADDR_BITS-1:2] : alu_data_in[ADDR_BITS-1:2];
    assign op_wdata  = wait_done ? wdata_q : memory_data_in;

    // Number of bytes touched by the access size.
    always_comb begin
        op_nbytes = 3'd4;
        case (op_size)
            2'b00:   op_nbytes = 3'd1;
            2'b01:   op_nbytes = 3'd2;
            default: op_nbytes = 3'd4;
        endcase
    end

    // One byte-wide RAM per lane. Lane gi receives data byte (gi - offset) mod 4,
    // so misaligned accesses without trapping wrap inside the addressed word.
    logic [3:0][7:0] rd_lane;
    logic [3:0][7:0] ld_byte;

    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        logic [1:0] rel;
        logic [1:0] src;
        logic       lane_we;
        logic [7:0] lane_wd;
        logic [7:0] rd_byte_q;
        logic [7:0] lane_mem [WORDS];

        assign rel     = 2'(gi) - op_off;
        assign lane_wd = op_wdata[{rel, 3'b000} +: 8];
        assign lane_we = complete && op_write && ({1'b0, rel} < op_nbytes);

        // Lane RAM with registered read; contents survive reset.
        always_ff @(posedge clk) begin
            if (lane_we) begin
                lane_mem[mem_idx] <= lane_wd;
            end
            if (complete) begin
                rd_byte_q <= lane_mem[mem_idx];
            end
        end

        assign rd_lane[gi] = rd_byte_q;
        // Result byte gi comes from lane (offset + gi) mod 4.
        assign src         = 2'(gi) + addr_q[1:0];
        assign ld_byte[gi] = rd_lane[src];
    end

    // Load formatting from the latched read word, sized and extended.
    logic [31:0] fmt_data;
    always_comb begin
        fmt_data = 32'd0;
        case (ctrl_q.mem_size)
            2'b00:   fmt_data = {{24{ctrl_q.mem_sign & ld_byte[0][7]}}, ld_byte[0]};
            2'b01:   fmt_data = {{16{ctrl_q.mem_sign & ld_byte[1][7]}}, ld_byte[1], ld_byte[0]};
            default: fmt_data = {ld_byte[3], ld_byte[2], ld_byte[1], ld_byte[0]};
        endcase
    end

    // Next-state logic: acceptance, latency countdown and output hold.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        out_valid_d = out_valid_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        ctrl_d      = ctrl_q;
        pc_d        = pc_q;
        mis_d       = mis_q;
        load_d      = load_q;

        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    addr_d  = alu_data_in;
                    wdata_d = memory_data_in;
                    ctrl_d  = control_in;
                    pc_d    = pc_in;
                    mis_d   = in_mis;
                    load_d  = in_load && in_real;
                    if (in_real && (LATENCY > 1)) begin
                        state_d = WAIT;
                        cnt_d   = 4'(LATENCY - 2);
                    end else begin
                        out_valid_d = 1'b1;
                    end
                end else if (out_valid_q && !out_ready) begin
                    state_d = HOLD;
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (reset_n) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            out_valid_q <= 1'b0;
            addr_q      <= 32'd0;
            wdata_q     <= 32'd0;
            ctrl_q      <= '0;
            pc_q        <= 32'd0;
            mis_q       <= 1'b0;
            load_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            ctrl_q      <= ctrl_d;
            pc_q        <= pc_d;
            mis_q       <= mis_d;
            load_q      <= load_d;
        end
    end

    assign out_valid       = out_valid_q;
    assign control_out     = ctrl_q;
    assign alu_data_out    = addr_q;
    assign pc_out          = pc_q;
    assign misaligned_out  = mis_q;
    assign memory_data_out = load_q ? fmt_data : 32'd0;
    assign busy            = (state_q != IDLE);

endmodule

// File: tb/tb_mem_stage_pipe.sv
// Directed bench for mem_stage_pipe: a LATENCY=1 and a LATENCY=3 instance
// share the data/control buses but have separate handshakes.

module tb_mem_stage_pipe;
    import mem_stage_pipe_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    control_type ctrl_in;
    logic [31:0] alu_in, md_in, pc_in;
    logic        in_valid1, in_valid3, out_ready1, out_ready3;
    logic        in_ready1, in_ready3, out_valid1, out_valid3;
    control_type ctrl_out1, ctrl_out3;
    logic [31:0] alu_out1, alu_out3, pc_out1, pc_out3, md_out1, md_out3;
    logic        mis1, mis3, busy1, busy3;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    mem_stage_pipe #(.ADDR_BITS(10), .LATENCY(1), .ALIGN_CHECK(1)) u1 (
        .clk(clk), .reset_n(rst), .in_valid(in_valid1), .in_ready(in_ready1),
        .alu_data_in(alu_in), .memory_data_in(md_in), .control_in(ctrl_in), .pc_in(pc_in),
        .out_valid(out_valid1), .out_ready(out_ready1), .control_out(ctrl_out1),
        .alu_data_out(alu_out1), .pc_out(pc_out1), .memory_data_out(md_out1),
        .misaligned_out(mis1), .busy(busy1)
    );

    mem_stage_pipe #(.ADDR_BITS(10), .LATENCY(3), .ALIGN_CHECK(1)) u3 (
        .clk(clk), .reset_n(rst), .in_valid(in_valid3), .in_ready(in_ready3),
        .alu_data_in(alu_in), .memory_data_in(md_in), .control_in(ctrl_in), .pc_in(pc_in),
        .out_valid(out_valid3), .out_ready(out_ready3), .control_out(ctrl_out3),
        .alu_data_out(alu_out3), .pc_out(pc_out3), .memory_data_out(md_out3),
        .misaligned_out(mis3), .busy(busy3)
    );

    function automatic control_type mk(input logic r, input logic w, input logic [1:0] sz, input logic sg);
        control_type c;
        c.mem_read  = r;
        c.mem_write = w;
        c.mem_size  = sz;
        c.mem_sign  = sg;
        return c;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Offer one op, wait (bounded) for acceptance and then for out_valid.
    // Returns at the first negedge where out_valid is seen; lat counts cycles.
    task automatic do_op(input bit sel3, input control_type c, input logic [31:0] a,
                         input logic [31:0] d, output logic [31:0] rdata,
                         output logic mis, output int lat);
        int n;
        @(negedge clk);
        ctrl_in = c;
        alu_in  = a;
        md_in   = d;
        pc_in   = a + 32'h100;
        if (sel3) in_valid3 = 1'b1; else in_valid1 = 1'b1;
        n = 0;
        while (!(sel3 ? in_ready3 : in_ready1) && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("accept_in_time", 32'(n < 50), 32'd1);
        @(negedge clk);
        in_valid1 = 1'b0;
        in_valid3 = 1'b0;
        lat = 1;
        while (!(sel3 ? out_valid3 : out_valid1) && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        rdata = sel3 ? md_out3 : md_out1;
        mis   = sel3 ? mis3 : mis1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic        mis;
        int          lat;
        control_type SW, SB, LW, LB, LBU, LH, LHU, NOP, RW;

        SW  = mk(1'b0, 1'b1, 2'b10, 1'b0);
        SB  = mk(1'b0, 1'b1, 2'b00, 1'b0);
        LW  = mk(1'b1, 1'b0, 2'b10, 1'b0);
        LB  = mk(1'b1, 1'b0, 2'b00, 1'b1);
        LBU = mk(1'b1, 1'b0, 2'b00, 1'b0);
        LH  = mk(1'b1, 1'b0, 2'b01, 1'b1);
        LHU = mk(1'b1, 1'b0, 2'b01, 1'b0);
        NOP = mk(1'b0, 1'b0, 2'b10, 1'b0);
        RW  = mk(1'b1, 1'b1, 2'b10, 1'b0);

        rst = 1'b1;
        ctrl_in = NOP; alu_in = 32'h0000_0abc; md_in = 32'h0; pc_in = 32'h0;
        in_valid1 = 1'b0; in_valid3 = 1'b0; out_ready1 = 1'b1; out_ready3 = 1'b1;

        // Reset state, and no acceptance while reset is held.
        repeat (3) @(negedge clk);
        in_valid1 = 1'b1;
        chk("rst_in_ready", 32'(in_ready1), 32'd0);
        chk("rst_busy", 32'(busy1), 32'd0);
        chk("rst_ctrl_out", 32'(ctrl_out1), 32'd0);
        chk("rst_md_out", md_out1, 32'd0);
        @(negedge clk);
        chk("rst_out_valid", 32'(out_valid1), 32'd0);
        chk("rst_alu_out", alu_out1, 32'd0);
        in_valid1 = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready", 32'(in_ready1), 32'd1);

        // Word store then byte/half/word loads (LATENCY=1).
        do_op(1'b0, SW, 32'h010, 32'hDEADBEEF, rd, mis, lat);
        chk("sw_lat", 32'(lat), 32'd1);
        chk("sw_data_zero", rd, 32'd0);
        do_op(1'b0, LB, 32'h013, 32'h0, rd, mis, lat);
        chk("lb_signed", rd, 32'hFFFFFFDE);
        chk("lb_lat", 32'(lat), 32'd1);
        do_op(1'b0, LBU, 32'h013, 32'h0, rd, mis, lat);
        chk("lbu", rd, 32'h000000DE);
        do_op(1'b0, LH, 32'h010, 32'h0, rd, mis, lat);
        chk("lh_signed", rd, 32'hFFFFBEEF);
        do_op(1'b0, LHU, 32'h012, 32'h0, rd, mis, lat);
        chk("lhu", rd, 32'h0000DEAD);
        do_op(1'b0, LW, 32'h010, 32'h0, rd, mis, lat);
        chk("lw", rd, 32'hDEADBEEF);
        chk("lw_pc_out", pc_out1, 32'h110);
        chk("lw_ctrl_out", 32'(ctrl_out1), 32'(LW));

        // Byte store only touches its own lane.
        do_op(1'b0, SB, 32'h011, 32'hFFFFFF5A, rd, mis, lat);
        do_op(1'b0, LW, 32'h010, 32'h0, rd, mis, lat);
        chk("sb_merge", rd, 32'hDEAD5AEF);

        // Back-to-back: two loads accepted on consecutive edges.
        @(negedge clk);
        ctrl_in = LBU; alu_in = 32'h010; in_valid1 = 1'b1;
        chk("b2b_ready0", 32'(in_ready1), 32'd1);
        @(negedge clk);
        chk("b2b_valid0", 32'(out_valid1), 32'd1);
        chk("b2b_data0", md_out1, 32'h000000EF);
        chk("b2b_ready1", 32'(in_ready1), 32'd1);
        alu_in = 32'h011;
        @(negedge clk);
        in_valid1 = 1'b0;
        chk("b2b_valid1", 32'(out_valid1), 32'd1);
        chk("b2b_data1", md_out1, 32'h0000005A);
        @(negedge clk);
        chk("b2b_drop", 32'(out_valid1), 32'd0);

        // Misaligned word store traps and leaves memory alone.
        do_op(1'b0, SW, 32'h004, 32'h11223344, rd, mis, lat);
        do_op(1'b0, SW, 32'h006, 32'hCAFEF00D, rd, mis, lat);
        chk("mis_sw_flag", 32'(mis), 32'd1);
        chk("mis_sw_lat", 32'(lat), 32'd1);
        do_op(1'b0, LW, 32'h004, 32'h0, rd, mis, lat);
        chk("mis_sw_unchanged", rd, 32'h11223344);
        chk("aligned_flag", 32'(mis), 32'd0);
        do_op(1'b0, LH, 32'h005, 32'h0, rd, mis, lat);
        chk("mis_lh_flag", 32'(mis), 32'd1);
        chk("mis_lh_data", rd, 32'd0);

        // Non-memory op passes through.
        do_op(1'b0, NOP, 32'h12345678, 32'h0, rd, mis, lat);
        chk("nop_data", rd, 32'd0);
        chk("nop_alu_out", alu_out1, 32'h12345678);

        // Read+write together is a store with zero result.
        do_op(1'b0, RW, 32'h020, 32'h77777777, rd, mis, lat);
        chk("rw_data_zero", rd, 32'd0);
        do_op(1'b0, LW, 32'h020, 32'h0, rd, mis, lat);
        chk("rw_stored", rd, 32'h77777777);

        // Address wrap modulo 1 KiB.
        do_op(1'b0, SW, 32'h404, 32'h0BADF00D, rd, mis, lat);
        do_op(1'b0, LW, 32'h004, 32'h0, rd, mis, lat);
        chk("wrap", rd, 32'h0BADF00D);

        // Output held in HOLD while downstream stalls, then one transfer.
        @(negedge clk);
        out_ready1 = 1'b0;
        ctrl_in = LW; alu_in = 32'h010; in_valid1 = 1'b1;
        @(negedge clk);
        in_valid1 = 1'b0;
        chk("hold_valid", 32'(out_valid1), 32'd1);
        chk("hold_data", md_out1, 32'hDEAD5AEF);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("hold_stable_valid", 32'(out_valid1), 32'd1);
            chk("hold_stable_data", md_out1, 32'hDEAD5AEF);
            chk("hold_busy", 32'(busy1), 32'd1);
            chk("hold_in_ready", 32'(in_ready1), 32'd0);
        end
        out_ready1 = 1'b1;
        @(negedge clk);
        chk("hold_release_drop", 32'(out_valid1), 32'd0);
        chk("hold_release_idle", 32'(busy1), 32'd0);

        // LATENCY=3 store, then latency timing of a stalled load.
        do_op(1'b1, SW, 32'h020, 32'hA5A5A5A5, rd, mis, lat);
        chk("l3_sw_lat", 32'(lat), 32'd3);
        @(negedge clk);
        out_ready3 = 1'b0;
        ctrl_in = LW; alu_in = 32'h020; in_valid3 = 1'b1;
        chk("l3_accept_ready", 32'(in_ready3), 32'd1);
        for (int k = 1; k <= 2; k++) begin
            @(negedge clk);
            in_valid3 = 1'b0;
            chk("l3_busy", 32'(busy3), 32'd1);
            chk("l3_in_ready", 32'(in_ready3), 32'd0);
            chk("l3_not_valid", 32'(out_valid3), 32'd0);
        end
        @(negedge clk);
        chk("l3_valid_t3", 32'(out_valid3), 32'd1);
        chk("l3_busy_t3", 32'(busy3), 32'd0);
        chk("l3_in_ready_t3", 32'(in_ready3), 32'd0);
        chk("l3_data", md_out3, 32'hA5A5A5A5);
        out_ready3 = 1'b1;
        @(negedge clk);
        chk("l3_drop", 32'(out_valid3), 32'd0);

        // Reset during WAIT of a store aborts the write.
        @(negedge clk);
        ctrl_in = SW; alu_in = 32'h020; md_in = 32'h12345678; in_valid3 = 1'b1;
        @(negedge clk);
        in_valid3 = 1'b0;
        chk("abort_in_wait", 32'(busy3), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("abort_busy", 32'(busy3), 32'd0);
        chk("abort_valid", 32'(out_valid3), 32'd0);
        rst = 1'b0;
        do_op(1'b1, LW, 32'h020, 32'h0, rd, mis, lat);
        chk("abort_mem_kept", rd, 32'hA5A5A5A5);
        chk("abort_lw_lat", 32'(lat), 32'd3);

        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mem_stage_pipe.md
MEM_STAGE_PIPE -- requirements
Module: mem_stage_pipe

Interface
REQ-001 Parameter ADDR_BITS, default 10: byte-address width of the internal data memory; depth is 2**ADDR_BITS bytes.
REQ-002 Parameter LATENCY, default 1: cycles from acceptance to result for loads and stores; legal range 1..8.
REQ-003 Parameter ALIGN_CHECK, default 1: 1 enables misaligned-access trapping; 0 wraps the access inside the addressed word.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 reset_n  input  1  synchronous, active-high reset; the block is held reset while it is 1, despite the suffix.
REQ-006 in_valid  input  1  upstream offers an instruction.
REQ-007 in_ready  output  1  stage can accept; a transfer occurs when in_valid and in_ready are both 1.
REQ-008 alu_data_in  input  32  effective address or ALU result.
REQ-009 memory_data_in  input  32  store data, in bits [7:0] for a byte store and [15:0] for a half store.
REQ-010 control_in  input  control_type  uses mem_read, mem_write, mem_size (00 byte, 01 half, 10 word, 11 word), mem_sign.
REQ-011 pc_in  input  32  instruction PC.
REQ-012 out_valid  output  1  result registers hold a valid instruction.
REQ-013 out_ready  input  1  downstream accepts; a transfer occurs when out_valid and out_ready are both 1.
REQ-014 control_out, alu_data_out, pc_out  output  control_type/32/32  registered copies of the accepted inputs.
REQ-015 memory_data_out  output  32  formatted load data; 0 for non-loads.
REQ-016 misaligned_out  output  1  accepted access violated alignment.
REQ-017 busy  output  1  FSM is not in IDLE.

Function
REQ-018 The FSM SHALL have three states: IDLE, WAIT and HOLD.
REQ-019 in_ready SHALL equal (state==IDLE) and (out_valid==0 or out_ready==1); it is 0 while reset_n is 1.
REQ-020 On acceptance, the block SHALL register the address, store data, control and pc.
REQ-021 A non-memory op, or a misaligned op with ALIGN_CHECK=1, SHALL assert out_valid on the edge after acceptance (latency 1) and SHALL have no memory effect.
REQ-022 A memory op with LATENCY=1 SHALL complete on the edge after acceptance.
REQ-023 A memory op with LATENCY>1 SHALL enter WAIT with a down-counter loaded with LATENCY-2 and SHALL complete on the edge where the counter is 0; out_valid rises exactly LATENCY cycles after acceptance.
REQ-024 A store SHALL write memory only on its completion edge: byte lanes from address[1:0], 1/2/4 bytes by mem_size.
REQ-025 A load SHALL sample memory on its completion edge, so a load accepted after a store observes the stored data.
REQ-026 Load formatting SHALL select the byte or half lane by address[1:0], then sign-extend if mem_sign=1 and zero-extend otherwise; a word load passes through unchanged.
REQ-027 Alignment SHALL be checked as: half requires address[0]=0; word requires address[1:0]=00.
REQ-028 When ALIGN_CHECK=0, a half access at offset 3 SHALL use bytes 3 and 0 of the same word.
REQ-029 The memory index SHALL be address[ADDR_BITS-1:0]; upper bits are ignored, so addresses wrap modulo 2**ADDR_BITS.
REQ-030 If mem_read and mem_write are both 1, the op SHALL be a store and memory_data_out SHALL be 0.
REQ-031 On completion, if out_valid=1 and out_ready=0, the FSM SHALL go to HOLD; otherwise it SHALL go to IDLE.
REQ-032 In HOLD, all outputs SHALL be stable until out_ready=1, then the FSM SHALL return to IDLE.
REQ-033 If out_valid=1 and out_ready=1 with no new completion in the same cycle, out_valid SHALL drop to 0 on the next edge.
REQ-034 An output transfer and an acceptance MAY occur in the same cycle (back-to-back throughput of 1 per cycle when LATENCY=1).

Reset
REQ-035 While reset_n=1: state=IDLE, counter=0, out_valid=0, busy=0, misaligned_out=0, all data outputs=0, control_out all-zero.
REQ-036 Reset mid-WAIT SHALL abort the op; a pending store SHALL NOT be written.
REQ-037 Memory contents SHALL NOT be cleared by reset.

Verification
REQ-038 LATENCY=1: word store of 0xDEADBEEF to 0x010, then byte load from 0x013 with mem_sign=1 -> 0xFFFFFFDE; with mem_sign=0 -> 0x000000DE.
REQ-039 LATENCY=3: load accepted at cycle T -> out_valid=1 at T+3, busy=1 for T+1..T+2, in_ready=0 for T+1..T+3 when out_ready=0.
REQ-040 ALIGN_CHECK=1: word store to 0x006 -> misaligned_out=1 at T+1, memory at 0x004..0x007 unchanged on a later readback.
REQ-041 out_ready=0 for 4 cycles after completion -> outputs held constant in HOLD; release -> exactly one transfer, out_valid=0 next cycle.
REQ-042 Reset asserted during WAIT of a store of 0x12345678 to 0x020 -> later word load of 0x020 returns the prior value.
REQ-043 ADDR_BITS=10: store to 0x404, then load from 0x004 -> same data (wrap-around).
